soc_system_pio_in_capture: RTL and testbench

Multi-channel Avalon-MM input PIO: the successor to the single-channel, data-only input port slaves in `soc_system`. It samples `CHANNELS` input buses of `WIDTH` bits each, optionally through a synchroniser. Per channel it provides edge capture, an interrupt mask and a saturating edge-event counter. A combined level interrupt is raised to the HPS.

---
 rtl/soc_system_pio_in_capture.sv | 86 ++++++++
 tb/tb_soc_system_pio_in_capture.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_in_capture.sv
// soc_system_pio_in_capture: multi-channel Avalon-MM input PIO with edge capture, IRQ mask and edge counters.
// Define PIO_IN_CAPTURE_SYNC_EN to pass in_port through a SYNC_STAGES-deep synchroniser.
module soc_system_pio_in_capture #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 2 + $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    input  logic [WIDTH*CHANNELS-1:0] in_port,
    output logic [31:0]               readdata,
    output logic                      irq
);
    logic [CHANNELS-1:0][WIDTH-1:0] w_s, w_edge, r_d, r_mask, r_cap;
    logic [CHANNELS-1:0][31:0]      r_cnt;
    logic [CHANNELS-1:0]            w_wsel;
    logic [ADDR_W-1:0]              w_ch;
    logic [1:0]                     w_reg;
    logic [31:0]                    w_rdata;
    logic [2:0]                     r_arm;
    logic                           w_wr, w_armed;

`ifdef PIO_IN_CAPTURE_SYNC_EN
    localparam int ARM = SYNC_STAGES + 1;
    logic [SYNC_STAGES-1:0][WIDTH*CHANNELS-1:0] r_sync;
    always_ff @(posedge clk) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
    assign w_s = r_sync[SYNC_STAGES-1];
`else
    localparam int ARM = 1;
    assign w_s = in_port;
`endif

    assign w_wr    = chipselect & ~write_n;
    assign w_ch    = address >> 2;
    assign w_reg   = address[1:0];
    assign w_armed = r_arm == 3'(ARM);
    // Edges are masked until the arm window expires so reset values of d never look like edges
    assign w_edge  = !w_armed        ? '0 :
                     EDGE_TYPE == 0  ? (w_s & ~r_d) :
                     EDGE_TYPE == 1  ? (~w_s & r_d) : (w_s ^ r_d);

    always_comb begin
        w_rdata = '0;
        w_wsel  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_wsel[c] = w_wr && (32'(w_ch) == c);
            if (32'(w_ch) == c)
                w_rdata = w_reg == 2'd0 ? 32'(w_s[c]) :
                          w_reg == 2'd1 ? 32'(r_mask[c]) :
                          w_reg == 2'd2 ? 32'(r_cap[c]) : r_cnt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_d      <= '0;
            r_arm    <= '0;
            r_mask   <= '0;
            r_cap    <= '0;
            r_cnt    <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            r_d      <= w_s;
            readdata <= chipselect ? w_rdata : 32'd0;
            irq      <= |(r_cap & r_mask);
            if (!w_armed) r_arm <= r_arm + 3'd1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wsel[c] && w_reg == 2'd1) r_mask[c] <= writedata[WIDTH-1:0];
                // A new edge overrides a simultaneous W1C on the same bit
                r_cap[c] <= (r_cap[c] & ~((w_wsel[c] && w_reg == 2'd2) ? writedata[WIDTH-1:0] : '0)) | w_edge[c];
                if (w_wsel[c] && w_reg == 2'd3) r_cnt[c] <= {31'd0, |w_edge[c]};
                else if (|w_edge[c] && !(&r_cnt[c])) r_cnt[c] <= r_cnt[c] + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// tb_soc_system_pio_in_capture: directed checks of two PIO instances (rising 32-bit, any-edge 8-bit).
module tb_soc_system_pio_in_capture;
`ifdef PIO_IN_CAPTURE_SYNC_EN
    localparam int N = 2;
`else
    localparam int N = 0;
`endif
    logic        clk, reset_n, chipselect, write_n;
    logic [3:0]  address;
    logic [31:0] writedata, rd_a, rd_b;
    logic [63:0] in_a;
    logic [15:0] in_b;
    logic        irq_a, irq_b;
    int          checks, errors;

    soc_system_pio_in_capture #(.WIDTH(32), .CHANNELS(2), .EDGE_TYPE(0), .ADDR_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

    soc_system_pio_in_capture #(.WIDTH(8), .CHANNELS(2), .EDGE_TYPE(2), .ADDR_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        cyc();
        chipselect = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        in_a = '1; in_b = '0;
        repeat (3) cyc();
        chk("reset_readdata", rd_a, 32'h0);
        chk("reset_irq", {31'd0, irq_a}, 32'h0);
        reset_n = 1'b1;
        repeat (N + 2) cyc();
        rd(4'h2); chk("arm_cap_ch0", rd_a, 32'h0);
        rd(4'h6); chk("arm_cap_ch1", rd_a, 32'h0);
        rd(4'h3); chk("arm_cnt_ch0", rd_a, 32'h0);
        chk("arm_irq", {31'd0, irq_a}, 32'h0);
        rd(4'h0); chk("data_ch0_ones", rd_a, 32'hFFFF_FFFF);

        wr(4'h5, 32'h1);
        in_a = '0;
        repeat (N + 2) cyc();
        in_a[32] = 1'b1;
        repeat (N) cyc();
        rd(4'h6); chk("cap_before_edge", rd_a, 32'h0);
        chk("irq_before", {31'd0, irq_a}, 32'h0);
        rd(4'h6); chk("cap_after_edge", rd_a, 32'h1);
        chk("irq_set", {31'd0, irq_a}, 32'h1);
        rd(4'h7); chk("cnt_ch1_one", rd_a, 32'h1);
        rd(4'h3); chk("cnt_ch0_fall_ignored", rd_a, 32'h0);

        in_a[32] = 1'b0;
        repeat (N + 1) cyc();
        in_a[32] = 1'b1;
        repeat (N) cyc();
        wr(4'h6, 32'h1);
        rd(4'h6); chk("w1c_set_wins", rd_a, 32'h1);
        chk("irq_held", {31'd0, irq_a}, 32'h1);
        rd(4'h7); chk("cnt_ch1_two", rd_a, 32'h2);
        wr(4'h6, 32'h1);
        chk("irq_lag", {31'd0, irq_a}, 32'h1);
        cyc();
        chk("irq_drop", {31'd0, irq_a}, 32'h0);
        rd(4'h6); chk("cap_cleared", rd_a, 32'h0);

        force dut_a.r_cnt = {32'hFFFF_FFFE, 32'h0};
        #1;
        release dut_a.r_cnt;
        in_a[32] = 1'b0;
        repeat (N + 1) cyc();
        in_a[32] = 1'b1;
        repeat (N + 1) cyc();
        rd(4'h7); chk("cnt_reach_max", rd_a, 32'hFFFF_FFFF);
        in_a[32] = 1'b0;
        repeat (N + 1) cyc();
        in_a[32] = 1'b1;
        repeat (N + 1) cyc();
        rd(4'h7); chk("cnt_saturate", rd_a, 32'hFFFF_FFFF);
        in_a[32] = 1'b0;
        repeat (N + 1) cyc();
        in_a[32] = 1'b1;
        repeat (N) cyc();
        wr(4'h7, 32'h0);
        rd(4'h7); chk("cnt_clear_with_edge", rd_a, 32'h1);

        wr(4'h5, 32'h0);
        chk("mask_irq_lag", {31'd0, irq_a}, 32'h1);
        cyc();
        chk("mask_irq_drop", {31'd0, irq_a}, 32'h0);

        wr(4'h9, 32'hFFFF_FFFF);
        wr(4'hD, 32'hFFFF_FFFF);
        wr(4'hF, 32'h0);
        wr(4'hB, 32'h0);
        rd(4'hB); chk("oob_read_cnt", rd_a, 32'h0);
        rd(4'h9); chk("oob_read_mask", rd_a, 32'h0);
        rd(4'h1); chk("mask_ch0_untouched", rd_a, 32'h0);
        rd(4'h5); chk("mask_ch1_untouched", rd_a, 32'h0);
        rd(4'h7); chk("cnt_ch1_untouched", rd_a, 32'h1);
        rd(4'h4); chk("data_ch1", rd_a, 32'h1);
        in_a[31:0] = 32'h1234_5678;
        repeat (N) cyc();
        rd(4'h0); chk("data_ch0_pattern", rd_a, 32'h1234_5678);

        in_b[7] = 1'b1;
        repeat (N + 1) cyc();
        in_b[7] = 1'b0;
        repeat (N + 1) cyc();
        rd(4'h2); chk("b_cap_any_edge", rd_b, 32'h80);
        rd(4'h3); chk("b_cnt_two", rd_b, 32'h2);
        rd(4'h6); chk("b_cap_ch1_quiet", rd_b, 32'h0);
        in_b[7:0] = 8'hA5;
        repeat (N) cyc();
        rd(4'h0); chk("b_data_zero_ext", rd_b, 32'h0000_00A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
